lc3_mem_ctrl: RTL and testbench



---
 rtl/lc3_mem_ctrl_pkg.sv | 13 +
 rtl/lc3_mem_ctrl_timer.sv | 30 +++
 rtl/lc3_mem_ctrl.sv | 125 ++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_ctrl_pkg.sv
// Shared LC-3 memory-controller types: sequencer state encoding and the I/O window base.
package lc3Pkg;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_BUS,
        MEM_IO,
        MEM_RESP
    } MemCtrlStates;

    localparam logic [15:0] IO_BASE_ADDR = 16'hFE00;

endpackage

// File: rtl/lc3_mem_ctrl_timer.sv
// Ack-wait watchdog for lc3_mem_ctrl: counts wait cycles and flags expiry at TIMEOUT-1.
// Compiled only with LC3_MEM_TIMEOUT_EN defined.
`ifdef LC3_MEM_TIMEOUT_EN
module lc3_mem_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    assign expire = en && (count == CW'(TIMEOUT - 1));

    // Saturates at expiry; the sequencer leaves BUS/IO on that cycle anyway.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-access sequencer: MAR/MDR level request -> bus or device-register req/ack, memRDY strobe.
// Optional ack watchdog enabled by LC3_MEM_TIMEOUT_EN (memERR stays 0 without it).
module lc3_mem_ctrl
    import lc3Pkg::*;
#(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 16,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_ADDR),
    parameter int                TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memEN,
    input  logic              memWE,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              memRDY,
    output logic              memERR,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              io_req,
    output logic              io_we,
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_wdata,
    input  logic [DATA_W-1:0] io_rdata,
    input  logic              io_ack
);

    MemCtrlStates      state;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqWdata;
    logic              reqWe;
    logic              timeout;

`ifdef LC3_MEM_TIMEOUT_EN
    logic timerEn;

    assign timerEn = (state == MEM_BUS) || (state == MEM_IO);

    lc3_mem_timer #(
        .TIMEOUT(TIMEOUT)
    ) uTimer (
        .clk   (clk),
        .rst   (rst),
        .clr   (!timerEn),
        .en    (timerEn),
        .expire(timeout)
    );
`else
    logic unusedTimeout;

    assign unusedTimeout = (TIMEOUT >= 2);
    assign timeout       = 1'b0;
`endif

    // Address/data ports come only from the latched request, never from MAR/MDR directly.
    assign bus_addr  = reqAddr;
    assign bus_wdata = reqWdata;
    assign io_addr   = reqAddr;
    assign io_wdata  = reqWdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MEM_IDLE;
            reqAddr  <= '0;
            reqWdata <= '0;
            reqWe    <= 1'b0;
            rdata    <= '0;
            memRDY   <= 1'b0;
            memERR   <= 1'b0;
            bus_req  <= 1'b0;
            bus_we   <= 1'b0;
            io_req   <= 1'b0;
            io_we    <= 1'b0;
        end else begin
            memRDY <= 1'b0;
            memERR <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (memEN) begin
                        reqAddr  <= addr;
                        reqWdata <= wdata;
                        reqWe    <= memWE;
                        if (addr >= IO_BASE) begin
                            state  <= MEM_IO;
                            io_req <= 1'b1;
                            io_we  <= memWE;
                        end else begin
                            state   <= MEM_BUS;
                            bus_req <= 1'b1;
                            bus_we  <= memWE;
                        end
                    end
                end
                MEM_BUS: begin
                    if (bus_ack || timeout) begin
                        state   <= MEM_RESP;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        memRDY  <= 1'b1;
                        memERR  <= timeout && !bus_ack;
                        if (!reqWe) rdata <= bus_ack ? bus_rdata : '0;
                    end
                end
                MEM_IO: begin
                    if (io_ack || timeout) begin
                        state  <= MEM_RESP;
                        io_req <= 1'b0;
                        io_we  <= 1'b0;
                        memRDY <= 1'b1;
                        memERR <= timeout && !io_ack;
                        if (!reqWe) rdata <= io_ack ? io_rdata : '0;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed, table-driven bench for lc3_mem_ctrl (TIMEOUT=8; timeout checks follow LC3_MEM_TIMEOUT_EN).
module tb_lc3_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memEN = 1'b0, memWE = 1'b0;
    logic [15:0] addr = '0, wdata = '0;
    logic [15:0] rdata;
    logic        memRDY, memERR;
    logic        bus_req, bus_we, io_req, io_we;
    logic [15:0] bus_addr, bus_wdata, io_addr, io_wdata;
    logic [15:0] bus_rdata = '0, io_rdata = '0;
    logic        bus_ack = 1'b0, io_ack = 1'b0;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    lc3_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .IO_BASE(16'hFE00), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .memEN(memEN), .memWE(memWE), .addr(addr), .wdata(wdata),
        .rdata(rdata), .memRDY(memRDY), .memERR(memERR),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          waitCyc;
        bit          io;
        bit          spur;
        logic [15:0] ackData;
        int          expLat;
        int          expBus;
        int          expIo;
        logic [15:0] expRdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one request from IDLE; returns at the negedge of the memRDY cycle (or after the budget).
    task automatic runTxn(input vec_t v, input bit keepEn, input int limit,
                          output int lat, output int busCyc, output int ioCyc,
                          output bit stable, output bit err, output int rdyAt);
        lat = -1; busCyc = 0; ioCyc = 0; stable = 1'b1; err = 1'b0; rdyAt = -1;
        @(posedge clk); #1;
        memEN = 1'b1; memWE = v.we; addr = v.addr; wdata = v.wdata;
        bus_rdata = v.ackData; io_rdata = v.ackData;
        for (int n = 1; n <= limit && lat < 0; n++) begin
            @(posedge clk); #1;
            addr = ~v.addr; wdata = ~v.wdata; memWE = ~v.we;
            bus_ack = v.io ? v.spur : (n == 1 + v.waitCyc);
            io_ack  = v.io ? (n == 1 + v.waitCyc) : v.spur;
            @(negedge clk);
            if (bus_req) begin
                busCyc++;
                if (bus_addr !== v.addr || bus_wdata !== v.wdata || bus_we !== v.we) stable = 1'b0;
            end
            if (io_req) begin
                ioCyc++;
                if (io_addr !== v.addr || io_wdata !== v.wdata || io_we !== v.we) stable = 1'b0;
            end
            if (memRDY) begin
                lat = n; err = memERR; rdyAt = cycle;
            end
        end
        bus_ack = 1'b0; io_ack = 1'b0;
        if (!keepEn) begin
            @(posedge clk); #1;
            memEN = 1'b0;
        end
    endtask

    initial begin
        int lat, busCyc, ioCyc, rdy1, rdy2;
        bit stable, err;
        bit sawRdy;

        //          we    addr      wdata     wait io  spur data      lat bus io  rdata
        vecs[0] = '{1'b0, 16'h3000, 16'h0000, 0,   0,  0,   16'h1234, 2,  1,  0,  16'h1234};
        vecs[1] = '{1'b1, 16'h4000, 16'hBEEF, 3,   0,  0,   16'h9999, 5,  4,  0,  16'h1234};
        vecs[2] = '{1'b0, 16'hFE02, 16'h0000, 0,   1,  1,   16'h8000, 2,  0,  1,  16'h8000};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 1,   1,  0,   16'hA5A5, 3,  0,  2,  16'hA5A5};
        vecs[4] = '{1'b0, 16'hFDFF, 16'h0000, 2,   0,  1,   16'h0F0F, 4,  3,  0,  16'h0F0F};
        vecs[5] = '{1'b1, 16'hFE00, 16'h5555, 0,   1,  0,   16'h7777, 2,  0,  1,  16'h0F0F};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ctl", {26'd0, memRDY, memERR, bus_req, bus_we, io_req, io_we}, 32'd0);
        check("reset_addr", {bus_addr, io_addr}, 32'd0);
        check("reset_data", {bus_wdata, io_wdata}, 32'd0);
        check("reset_rdata", {16'd0, rdata}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            runTxn(vecs[i], 1'b0, 40, lat, busCyc, ioCyc, stable, err, rdy1);
            check($sformatf("v%0d_latency", i), lat, vecs[i].expLat);
            check($sformatf("v%0d_bus_cycles", i), busCyc, vecs[i].expBus);
            check($sformatf("v%0d_io_cycles", i), ioCyc, vecs[i].expIo);
            check($sformatf("v%0d_req_stable", i), {31'd0, stable}, 32'd1);
            check($sformatf("v%0d_memERR", i), {31'd0, err}, 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_rdata", i), {16'd0, rdata}, {16'd0, vecs[i].expRdata});
            check($sformatf("v%0d_rdy_one_cycle", i), {31'd0, memRDY}, 32'd0);
        end

        // Back-to-back reads with memEN held across both.
        runTxn('{1'b0, 16'h0010, 16'h0, 0, 0, 0, 16'h1111, 2, 1, 0, 16'h1111}, 1'b1, 40,
               lat, busCyc, ioCyc, stable, err, rdy1);
        check("b2b_first_latency", lat, 2);
        check("b2b_first_rdata", {16'd0, rdata}, 32'h1111);
        runTxn('{1'b0, 16'h0011, 16'h0, 0, 0, 0, 16'h2222, 2, 1, 0, 16'h2222}, 1'b0, 40,
               lat, busCyc, ioCyc, stable, err, rdy2);
        check("b2b_second_latency", lat, 2);
        check("b2b_second_addr_stable", {31'd0, stable}, 32'd1);
        check("b2b_rdy_spacing", rdy2 - rdy1, 3);
        check("b2b_second_rdata", {16'd0, rdata}, 32'h2222);

        // Read with no ack at all.
        runTxn('{1'b0, 16'h1000, 16'h0, 1000, 0, 0, 16'h7777, 9, 8, 0, 16'h0000}, 1'b0, 40,
               lat, busCyc, ioCyc, stable, err, rdy1);
`ifdef LC3_MEM_TIMEOUT_EN
        check("timeout_latency", lat, 9);
        check("timeout_req_cycles", busCyc, 8);
        check("timeout_memERR", {31'd0, err}, 32'd1);
        check("timeout_rdata", {16'd0, rdata}, 32'h0000);
`else
        check("noack_no_rdy", lat, -1);
        check("noack_req_held", busCyc, 40);
        @(posedge clk); #1 bus_ack = 1'b1;
        @(posedge clk); #1 bus_ack = 1'b0;
        @(negedge clk);
        check("late_ack_completes", {31'd0, memRDY}, 32'd1);
        check("late_ack_no_err", {31'd0, memERR}, 32'd0);
`endif

        // Reset during the BUS wait, followed by an ack that must be ignored.
        repeat (2) @(posedge clk);
        #1 memEN = 1'b1; memWE = 1'b0; addr = 16'h2000; bus_rdata = 16'hDEAD;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; memEN = 1'b0;
        @(negedge clk);
        check("pre_reset_bus_req", {31'd0, bus_req}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0; bus_ack = 1'b1;
        @(negedge clk);
        check("midreset_ctl", {26'd0, memRDY, memERR, bus_req, bus_we, io_req, io_we}, 32'd0);
        check("midreset_addr", {16'd0, bus_addr}, 32'd0);
        check("midreset_rdata", {16'd0, rdata}, 32'd0);
        sawRdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (memRDY || bus_req) sawRdy = 1'b1;
        end
        bus_ack = 1'b0;
        check("late_ack_ignored", {31'd0, sawRdy}, 32'd0);
        check("late_ack_rdata", {16'd0, rdata}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
